// File: rtl/gcd_pkg.sv
// Shared types and widths for the round-robin GCD engine arbiter.
package gcd_pkg;

  localparam int unsigned GCD_W = 16;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} gcd_arb_state_t;

  // Index width for a requester vector of n entries (at least 1 bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gcd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick
  import gcd_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] sel,
  output logic [IW-1:0]   idx
);

  logic found;

  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned j;
      j = (32'(ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        sel[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin scheduler sharing one GCD subtraction engine between NREQ requesters.
// Optional RUN watchdog enabled by defining GCD_ARB_TIMEOUT_EN.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int unsigned      NREQ       = 4,
  parameter logic [GCD_W-1:0] MAX_CYCLES = 16'd1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*GCD_W-1:0] req_x,
  input  logic [NREQ*GCD_W-1:0] req_y,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [GCD_W-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  eng_rst,
  output logic                  eng_start,
  output logic [GCD_W-1:0]      eng_xi,
  output logic [GCD_W-1:0]      eng_yi,
  input  logic [GCD_W-1:0]      eng_xo,
  input  logic                  eng_rdy
);

  localparam int unsigned IW = idx_w(NREQ);

  gcd_arb_state_t   state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    cur_q, cur_d;
  logic [GCD_W-1:0] op_x_q, op_x_d;
  logic [GCD_W-1:0] op_y_q, op_y_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [GCD_W-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q;
  logic             eng_start_q;

  logic [NREQ-1:0]  pick_sel;
  logic [IW-1:0]    pick_idx;

`ifdef GCD_ARB_TIMEOUT_EN
  logic [GCD_W-1:0] cnt_q, cnt_d;
`else
  logic unused_max_cycles;
  assign unused_max_cycles = ^MAX_CYCLES;
`endif

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .sel (pick_sel),
    .idx (pick_idx)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cur_d       = cur_q;
    op_x_d      = op_x_q;
    op_y_d      = op_y_q;
    gnt_d       = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef GCD_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          op_x_d  = req_x[32'(pick_idx)*GCD_W +: GCD_W];
          op_y_d  = req_y[32'(pick_idx)*GCD_W +: GCD_W];
          cur_d   = pick_idx;
          gnt_d   = pick_sel;
          state_d = LOAD;
        end
      end
      LOAD: begin
`ifdef GCD_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = RUN;
      end
      RUN: begin
        if (eng_rdy) begin
          rsp_data_d         = eng_xo;
          rsp_err_d          = 1'b0;
          rsp_valid_d        = '0;
          rsp_valid_d[cur_q] = 1'b1;
          state_d            = RESP;
        end
`ifdef GCD_ARB_TIMEOUT_EN
        else begin
          // Ready on the limit cycle takes priority over the timeout.
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == MAX_CYCLES) begin
            rsp_data_d         = '0;
            rsp_err_d          = 1'b1;
            rsp_valid_d        = '0;
            rsp_valid_d[cur_q] = 1'b1;
            state_d            = RESP;
          end
        end
`endif
      end
      RESP: begin
        if (rsp_ready[cur_q]) begin
          rsp_valid_d = '0;
          ptr_d       = (cur_q == IW'(NREQ-1)) ? '0 : cur_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cur_q       <= '0;
      op_x_q      <= '0;
      op_y_q      <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      eng_start_q <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_q       <= cur_d;
      op_x_q      <= op_x_d;
      op_y_q      <= op_y_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= (state_d != IDLE);
      eng_start_q <= (state_d == RUN);
`ifdef GCD_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign eng_rst   = rst;
  assign eng_start = eng_start_q;
  assign eng_xi    = op_x_q;
  assign eng_yi    = op_y_q;

endmodule
